ex_mem_elastic_stage: RTL

Parametrised, flow-controlled EX/MEM pipeline stage between the execute stage and the data-memory stage. It replaces the free-running EX/MEM register with valid/ready handshaking, a two-entry skid buffer for data-memory back-pressure, synchronous flush for branch/jump redirects, and defined reset values on every output. All payload fields are the same as in the current EX/MEM register. Control outputs are qualified by the valid bit, so a bubble can never write memory or the register file.

---
 rtl/pipe_pkg.sv | 38 +++
 rtl/pipe_skid_buf.sv | 121 ++++++++++++
 rtl/ex_mem_elastic_stage.sv | 112 +++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared types and constants for the flow-controlled pipeline stages.
package pipe_pkg;

    // Default datapath and register-address widths of the core.
    localparam int unsigned PIPE_XLEN    = 32;
    localparam int unsigned PIPE_RADDR_W = 5;

    // Elastic stage occupancy: no entry, main slot only, main and skid slots.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } skid_state_t;

    // EX/MEM payload at the default core widths.
    typedef struct packed {
        logic [PIPE_XLEN-1:0]    pcsrc;
        logic [PIPE_XLEN-1:0]    pc_new;
        logic [PIPE_XLEN-1:0]    offset;
        logic [PIPE_XLEN-1:0]    alu_result;
        logic [PIPE_XLEN-1:0]    read_data2;
        logic                    reg_write;
        logic                    mem_read;
        logic                    mem_write;
        logic                    pc_select;
        logic [1:0]              dmem_to_reg;
        logic [PIPE_RADDR_W-1:0] write_addr_reg;
    } ex_mem_payload_t;

    localparam ex_mem_payload_t EX_MEM_PAYLOAD_RST = '0;

    // Packed payload width for arbitrary XLEN / RADDR_W builds.
    function automatic int unsigned ex_mem_payload_width(input int unsigned xlen,
                                                         input int unsigned raddr_w);
        return 5 * xlen + 4 + 2 + raddr_w;
    endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic valid/ready elastic buffer with synchronous flush.
// SKID_EN=1: two slots, registered ready_o. SKID_EN=0: one slot, pass-through ready.
module pipe_skid_buf
    import pipe_pkg::*;
#(
    parameter int unsigned WIDTH   = 8,
    parameter bit          SKID_EN = 1'b1
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             flush_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] data_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] data_o
);

    if (SKID_EN) begin : g_skid
        skid_state_t      state_q, state_d;
        logic [WIDTH-1:0] main_q, main_d;
        logic [WIDTH-1:0] skid_q, skid_d;
        logic             ready_q, valid_q;

        // Next-state and slot loading; flush overrides every transition.
        always_comb begin
            state_d = state_q;
            main_d  = main_q;
            skid_d  = skid_q;
            case (state_q)
                EMPTY: begin
                    if (valid_i) begin
                        main_d  = data_i;
                        state_d = FULL;
                    end
                end
                FULL: begin
                    if (valid_i && ready_i) begin
                        main_d = data_i;
                    end else if (valid_i) begin
                        skid_d  = data_i;
                        state_d = SKID;
                    end else if (ready_i) begin
                        state_d = EMPTY;
                    end
                end
                SKID: begin
                    // Input is blocked here; skid drains into main first to keep order.
                    if (ready_i) begin
                        main_d  = skid_q;
                        state_d = FULL;
                    end
                end
                default: state_d = EMPTY;
            endcase
            if (flush_i) begin
                state_d = EMPTY;
                main_d  = main_q;
                skid_d  = skid_q;
            end
        end

        // State, slots and registered handshake flags.
        always_ff @(posedge clk_i) begin
            if (reset_i) begin
                state_q <= EMPTY;
                main_q  <= '0;
                skid_q  <= '0;
                ready_q <= 1'b1;
                valid_q <= 1'b0;
            end else begin
                state_q <= state_d;
                main_q  <= main_d;
                skid_q  <= skid_d;
                ready_q <= (state_d != SKID);
                valid_q <= (state_d != EMPTY);
            end
        end

        assign ready_o = ready_q;
        assign valid_o = valid_q;
        assign data_o  = main_q;
    end else begin : g_reg
        logic [WIDTH-1:0] main_q, main_d;
        logic             valid_q, valid_d;
        logic             load;

        assign ready_o = ready_i | ~valid_q;
        assign load    = valid_i & ready_o;

        // Single-slot next state; a consumed entry without a replacement empties the stage.
        always_comb begin
            valid_d = valid_q;
            main_d  = main_q;
            if (flush_i) begin
                valid_d = 1'b0;
            end else if (load) begin
                valid_d = 1'b1;
                main_d  = data_i;
            end else if (ready_i) begin
                valid_d = 1'b0;
            end
        end

        // Slot and valid flag.
        always_ff @(posedge clk_i) begin
            if (reset_i) begin
                valid_q <= 1'b0;
                main_q  <= '0;
            end else begin
                valid_q <= valid_d;
                main_q  <= main_d;
            end
        end

        assign valid_o = valid_q;
        assign data_o  = main_q;
    end

endmodule

// File: rtl/ex_mem_elastic_stage.sv
// EX/MEM pipeline stage with valid/ready flow control, skid buffering and flush.
// Control outputs are qualified by valid_o so a bubble never writes memory or registers.
module ex_mem_elastic_stage
    import pipe_pkg::*;
#(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned RADDR_W = 5,
    parameter bit          SKID_EN = 1'b1
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               flush_i,

    input  logic               valid_i,
    output logic               ready_o,
    input  logic [XLEN-1:0]    pcsrc_i,
    input  logic [XLEN-1:0]    pc_new_i,
    input  logic [XLEN-1:0]    offset_i,
    input  logic [XLEN-1:0]    alu_result_i,
    input  logic [XLEN-1:0]    read_data2_i,
    input  logic               reg_write_i,
    input  logic               mem_read_i,
    input  logic               mem_write_i,
    input  logic               pc_select_i,
    input  logic [1:0]         dmem_to_reg_i,
    input  logic [RADDR_W-1:0] write_addr_reg_i,

    output logic               valid_o,
    input  logic               ready_i,
    output logic [XLEN-1:0]    em_pcsrc_o,
    output logic [XLEN-1:0]    em_pc_new_o,
    output logic [XLEN-1:0]    em_offset_o,
    output logic [XLEN-1:0]    em_alu_result_o,
    output logic [XLEN-1:0]    em_read_data2_o,
    output logic               em_reg_write_o,
    output logic               em_mem_read_o,
    output logic               em_mem_write_o,
    output logic               em_pc_select_o,
    output logic [1:0]         em_dmem_to_reg_o,
    output logic [RADDR_W-1:0] em_write_addr_reg_o
);

    localparam int unsigned PAYLOAD_W = ex_mem_payload_width(XLEN, RADDR_W);

    // Same field layout as ex_mem_payload_t, sized by this instance's parameters.
    typedef struct packed {
        logic [XLEN-1:0]    pcsrc;
        logic [XLEN-1:0]    pc_new;
        logic [XLEN-1:0]    offset;
        logic [XLEN-1:0]    alu_result;
        logic [XLEN-1:0]    read_data2;
        logic               reg_write;
        logic               mem_read;
        logic               mem_write;
        logic               pc_select;
        logic [1:0]         dmem_to_reg;
        logic [RADDR_W-1:0] write_addr_reg;
    } payload_t;

    payload_t             in_pl;
    payload_t             out_pl;
    logic [PAYLOAD_W-1:0] out_raw;

    // Pack the execute-stage fields into one payload word.
    always_comb begin
        in_pl                = '0;
        in_pl.pcsrc          = pcsrc_i;
        in_pl.pc_new         = pc_new_i;
        in_pl.offset         = offset_i;
        in_pl.alu_result     = alu_result_i;
        in_pl.read_data2     = read_data2_i;
        in_pl.reg_write      = reg_write_i;
        in_pl.mem_read       = mem_read_i;
        in_pl.mem_write      = mem_write_i;
        in_pl.pc_select      = pc_select_i;
        in_pl.dmem_to_reg    = dmem_to_reg_i;
        in_pl.write_addr_reg = write_addr_reg_i;
    end

    pipe_skid_buf #(
        .WIDTH   (PAYLOAD_W),
        .SKID_EN (SKID_EN)
    ) u_skid_buf (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .flush_i (flush_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .data_i  (in_pl),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .data_o  (out_raw)
    );

    assign out_pl = payload_t'(out_raw);

    // Unpack; data fields may be stale when invalid, controls are forced low.
    always_comb begin
        em_pcsrc_o          = out_pl.pcsrc;
        em_pc_new_o         = out_pl.pc_new;
        em_offset_o         = out_pl.offset;
        em_alu_result_o     = out_pl.alu_result;
        em_read_data2_o     = out_pl.read_data2;
        em_dmem_to_reg_o    = out_pl.dmem_to_reg;
        em_write_addr_reg_o = out_pl.write_addr_reg;
        em_reg_write_o      = out_pl.reg_write & valid_o;
        em_mem_read_o       = out_pl.mem_read  & valid_o;
        em_mem_write_o      = out_pl.mem_write & valid_o;
        em_pc_select_o      = out_pl.pc_select & valid_o;
    end

endmodule
